multi_cycle_control_unit: RTL and testbench

FSM controller that sequences the shared multi-cycle RV32I datapath. The datapath has one ALU, one unified memory, the IR/MDR/A/B/ALUOut registers and the ImmediateGenerator. The controller steps each instruction through IF/ID/EX/MEM/WB. It decodes the opcode from IR, drives all mux selects and write enables, waits on the memory ready handshake, and halts on ECALL(x17==10), illegal opcode or memory timeout.

---
 rtl/multi_cycle_control_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over the shared
// datapath, handles the memory handshake with a wait timeout, and halts.
module multi_cycle_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PCN  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    // Counter wide enough to hold MEM_TIMEOUT; saturates when timeout is off.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;

    logic is_r, is_i, is_ld, is_st;
    logic is_br, is_jal, is_jalr, is_sys;
    logic legal;
    logic expired;
    logic [CW-1:0] cnt_inc;

    // Opcode class decode and wait-timeout detection.
    always_comb begin
        is_r    = (opcode == OP_R);
        is_i    = (opcode == OP_I);
        is_ld   = (opcode == OP_LOAD);
        is_st   = (opcode == OP_STORE);
        is_br   = (opcode == OP_BR);
        is_jal  = (opcode == OP_JAL);
        is_jalr = (opcode == OP_JALR);
        is_sys  = (opcode == OP_SYS);
        legal   = is_r | is_i | is_ld | is_st | is_br
                | is_jal | is_jalr | is_sys;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        expired = (MEM_TIMEOUT != 0) &&
                  ((int'(cnt_q) + 1) >= MEM_TIMEOUT);
    end

    // Next-state logic and control outputs; everything forced low in reset.
    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        cnt_d         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        is_halted     = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end else if (expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ID: begin
                alu_src_b = 2'b10;
                if (is_sys) begin
                    state_d = ecall_halt ? S_HALT : S_PCN;
                end else if (!legal) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (1'b1)
                    is_r: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    is_i: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    is_ld, is_st: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    is_br: begin
                        alu_src_a     = 1'b1;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        state_d       = bcond ? S_IF : S_PCN;
                    end
                    is_jal: begin
                        alu_src_b = 2'b01;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        state_d   = S_IF;
                    end
                    is_jalr: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_WB;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_ld;
                mem_write = is_st;
                if (mem_ready) begin
                    mdr_write = is_ld;
                    state_d   = is_ld ? S_WB : S_PCN;
                end else if (expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                if (is_ld) begin
                    wb_sel = 2'b01;
                end else if (is_jalr) begin
                    wb_sel    = 2'b10;
                    pc_source = 1'b1;
                end
                state_d = S_IF;
            end
            S_PCN: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mdr_write     = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = 2'b00;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            is_halted     = 1'b0;
        end
    end

    assign fault = fault_q & ~reset;

    // State, wait counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit (MEM_TIMEOUT = 4).
// Each step checks the full control vector against a hand-built constant.
module tb_multi_cycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       ecall_halt;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, i_or_d;
    logic       mem_read, mem_write, ir_write, mdr_write, reg_write;
    logic [1:0] wb_sel, alu_src_b, alu_op;
    logic       alu_src_a, is_halted, fault;

    int tests = 0;
    int fails = 0;

    multi_cycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    wire [17:0] obs = {pc_write, pc_write_cond, pc_source, i_or_d,
                       mem_read, mem_write, ir_write, mdr_write,
                       reg_write, wb_sel, alu_src_a, alu_src_b,
                       alu_op, is_halted, fault};

    function automatic logic [17:0] v(
        bit pcw, bit pcc, bit pcs, bit iod, bit mr, bit mw,
        bit irw, bit mdw, bit rw, bit [1:0] wb, bit asa,
        bit [1:0] asb, bit [1:0] aop, bit h, bit f);
        return {pcw, pcc, pcs, iod, mr, mw, irw, mdw, rw,
                wb, asa, asb, aop, h, f};
    endfunction

    task automatic chk(input string tag, input logic [17:0] o,
                       input logic [17:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s got=%b want=%b", tag, o, e);
        end
    endtask

    // Check at the falling edge, then advance to just after the next rise.
    task automatic cyc(input string tag, input logic [17:0] e);
        @(negedge clk);
        chk(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic [17:0] ZERO, IF_NR, IF_R, ID, EX_R, EX_I, EX_LS, EX_BR;
    logic [17:0] EX_JAL, EX_JALR, MEM_LD_NR, MEM_LD_R, MEM_ST;
    logic [17:0] WB_R, WB_LD, WB_JALR, PCN, HALT_OK, HALT_F;

    initial begin
        //          pcw pcc pcs iod mr mw irw mdw rw wb asa asb aop h f
        ZERO      = v(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        IF_NR     = v(0,0,0,0,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        IF_R      = v(0,0,0,0,1,0,1,0,0,2'b00,0,2'b00,2'b00,0,0);
        ID        = v(0,0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,0);
        EX_R      = v(0,0,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0);
        EX_I      = v(0,0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b10,0,0);
        EX_LS     = v(0,0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0);
        EX_BR     = v(0,1,1,0,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,0);
        EX_JAL    = v(1,0,1,0,0,0,0,0,1,2'b10,0,2'b01,2'b00,0,0);
        EX_JALR   = v(0,0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0);
        MEM_LD_NR = v(0,0,0,1,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        MEM_LD_R  = v(0,0,0,1,1,0,0,1,0,2'b00,0,2'b00,2'b00,0,0);
        MEM_ST    = v(0,0,0,1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        WB_R      = v(1,0,0,0,0,0,0,0,1,2'b00,0,2'b01,2'b00,0,0);
        WB_LD     = v(1,0,0,0,0,0,0,0,1,2'b01,0,2'b01,2'b00,0,0);
        WB_JALR   = v(1,0,1,0,0,0,0,0,1,2'b10,0,2'b01,2'b00,0,0);
        PCN       = v(1,0,0,0,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0);
        HALT_OK   = v(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0);
        HALT_F    = v(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1);

        reset = 1'b1; opcode = OP_R; bcond = 1'b0;
        ecall_halt = 1'b0; mem_ready = 1'b1;
        cyc("rst0", ZERO);
        cyc("rst1", ZERO);
        reset = 1'b0;

        // ADD with mem_ready always high
        cyc("add_if", IF_R);
        cyc("add_id", ID);
        cyc("add_ex", EX_R);
        cyc("add_wb", WB_R);

        // LW: 3 wait cycles in IF, 2 in MEM
        opcode = OP_LD; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_if_wait", IF_NR);
        mem_ready = 1'b1;
        cyc("lw_if", IF_R);
        mem_ready = 1'b0;
        cyc("lw_id", ID);
        cyc("lw_ex", EX_LS);
        for (int i = 0; i < 2; i++) cyc("lw_mem_wait", MEM_LD_NR);
        mem_ready = 1'b1;
        cyc("lw_mem", MEM_LD_R);
        cyc("lw_wb", WB_LD);

        // BEQ taken, then not taken
        opcode = OP_BR; bcond = 1'b1;
        cyc("beqt_if", IF_R);
        cyc("beqt_id", ID);
        cyc("beqt_ex", EX_BR);
        bcond = 1'b0;
        cyc("beqn_if", IF_R);
        cyc("beqn_id", ID);
        cyc("beqn_ex", EX_BR);
        cyc("beqn_pcn", PCN);

        // SW with immediate ready
        opcode = OP_ST;
        cyc("sw_if", IF_R);
        cyc("sw_id", ID);
        cyc("sw_ex", EX_LS);
        cyc("sw_mem", MEM_ST);
        cyc("sw_pcn", PCN);

        // JAL, JALR, ADDI, non-halting ECALL
        opcode = OP_JAL;
        cyc("jal_if", IF_R);
        cyc("jal_id", ID);
        cyc("jal_ex", EX_JAL);
        opcode = OP_JALR;
        cyc("jalr_if", IF_R);
        cyc("jalr_id", ID);
        cyc("jalr_ex", EX_JALR);
        cyc("jalr_wb", WB_JALR);
        opcode = OP_I;
        cyc("addi_if", IF_R);
        cyc("addi_id", ID);
        cyc("addi_ex", EX_I);
        cyc("addi_wb", WB_R);
        opcode = OP_SYS; ecall_halt = 1'b0;
        cyc("ecall_if", IF_R);
        cyc("ecall_id", ID);
        cyc("ecall_pcn", PCN);

        // SW never acknowledged: MEM timeout
        opcode = OP_ST;
        cyc("swto_if", IF_R);
        cyc("swto_id", ID);
        cyc("swto_ex", EX_LS);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("swto_mem", MEM_ST);
        cyc("swto_halt", HALT_F);
        reset = 1'b1;
        cyc("rst_halt", ZERO);
        reset = 1'b0;

        // IF timeout after 4 waiting cycles
        for (int i = 0; i < 4; i++) cyc("ifto_wait", IF_NR);
        cyc("ifto_halt", HALT_F);
        reset = 1'b1;
        cyc("rst_ifto", ZERO);
        reset = 1'b0;

        // Ready on the 4th cycle beats the timeout, then halting ECALL
        for (int i = 0; i < 3; i++) cyc("ifok_wait", IF_NR);
        mem_ready = 1'b1;
        cyc("ifok_if", IF_R);
        opcode = OP_SYS; ecall_halt = 1'b1;
        cyc("ifok_id", ID);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            bcond = 1'($urandom_range(0, 1));
            cyc("halt_frozen", HALT_OK);
        end
        reset = 1'b1;
        cyc("rst_ecall", ZERO);
        reset = 1'b0;

        // Illegal opcode
        opcode = 7'b0000000; mem_ready = 1'b1;
        cyc("ill_if", IF_R);
        cyc("ill_id", ID);
        cyc("ill_halt", HALT_F);
        reset = 1'b1;
        cyc("rst_ill", ZERO);
        reset = 1'b0; mem_ready = 1'b0;
        cyc("post_rst_if", IF_NR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
